// File: rtl/axil_pkg.sv
// Shared types and constants for the AXI4-Lite command master.
package axil_pkg;

  localparam int unsigned AXIL_ADDR_MAX_W = 32;
  localparam int unsigned AXIL_DATA_W     = 32;
  localparam int unsigned AXIL_STRB_W     = AXIL_DATA_W / 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_AW_W = 3'd1,
    ST_WR_B    = 3'd2,
    ST_RD_AR   = 3'd3,
    ST_RD_R    = 3'd4,
    ST_RSP     = 3'd5
  } axil_mst_state_t;

  typedef struct packed {
    logic                       we;
    logic [AXIL_ADDR_MAX_W-1:0] addr;
    logic [AXIL_DATA_W-1:0]     wdata;
    logic [AXIL_STRB_W-1:0]     wstrb;
  } axil_cmd_t;

  // Word-align a byte address (AXI4-Lite transfers here are always full words).
  function automatic logic [AXIL_ADDR_MAX_W-1:0] word_align(input logic [AXIL_ADDR_MAX_W-1:0] a);
    return {a[AXIL_ADDR_MAX_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/axil_cmd_master.sv
// Single-outstanding AXI4-Lite master: command stream in, AXI transaction out,
// response (data, resp, latency) stream back.
module axil_cmd_master
  import axil_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LAT_WIDTH  = 16
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  // command stream
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_we,
  input  logic [ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [AXIL_DATA_W-1:0]    cmd_wdata,
  input  logic [AXIL_STRB_W-1:0]    cmd_wstrb,
  // response stream
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic                      rsp_we,
  output logic [AXIL_DATA_W-1:0]    rsp_rdata,
  output logic [1:0]                rsp_resp,
  output logic [LAT_WIDTH-1:0]      rsp_latency,
  // AXI4-Lite write address
  output logic [ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  output logic [2:0]                M_AXI_AWPROT,
  output logic                      M_AXI_AWVALID,
  input  logic                      M_AXI_AWREADY,
  // AXI4-Lite write data
  output logic [DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  output logic                      M_AXI_WVALID,
  input  logic                      M_AXI_WREADY,
  // AXI4-Lite write response
  input  logic [1:0]                M_AXI_BRESP,
  input  logic                      M_AXI_BVALID,
  output logic                      M_AXI_BREADY,
  // AXI4-Lite read address
  output logic [ADDR_WIDTH-1:0]     M_AXI_ARADDR,
  output logic [2:0]                M_AXI_ARPROT,
  output logic                      M_AXI_ARVALID,
  input  logic                      M_AXI_ARREADY,
  // AXI4-Lite read data
  input  logic [DATA_WIDTH-1:0]     M_AXI_RDATA,
  input  logic [1:0]                M_AXI_RRESP,
  input  logic                      M_AXI_RVALID,
  output logic                      M_AXI_RREADY
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;

  // Elaboration-time parameter checks.
  if (DATA_WIDTH != AXIL_DATA_W) begin : g_bad_data_width
    $error("axil_cmd_master: DATA_WIDTH must be 32");
  end
  if (ADDR_WIDTH > AXIL_ADDR_MAX_W) begin : g_bad_addr_width
    $error("axil_cmd_master: ADDR_WIDTH must not exceed 32");
  end

  axil_mst_state_t            state_q, state_d;
  axil_cmd_t                  cmd_q, cmd_d;
  logic                       awvalid_q, awvalid_d;
  logic                       wvalid_q, wvalid_d;
  logic                       bready_q, bready_d;
  logic                       arvalid_q, arvalid_d;
  logic                       rready_q, rready_d;
  logic                       rsp_valid_q, rsp_valid_d;
  logic [AXIL_DATA_W-1:0]     rdata_q, rdata_d;
  logic [1:0]                 resp_q, resp_d;
  logic [LAT_WIDTH-1:0]       lat_q, lat_d;
  logic [LAT_WIDTH-1:0]       lat_inc;

  // State and datapath registers.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q     <= ST_IDLE;
      cmd_q       <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      resp_q      <= RESP_OKAY;
      lat_q       <= '0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      resp_q      <= resp_d;
      lat_q       <= lat_d;
    end
  end

  // Next-state, handshake flags, response capture and saturating latency count.
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    rsp_valid_d = rsp_valid_q;
    rdata_d     = rdata_q;
    resp_d      = resp_q;
    lat_d       = lat_q;
    lat_inc     = (lat_q == {LAT_WIDTH{1'b1}}) ? lat_q : lat_q + LAT_WIDTH'(1);

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          cmd_d.we    = cmd_we;
          cmd_d.addr  = word_align(AXIL_ADDR_MAX_W'(cmd_addr));
          cmd_d.wdata = cmd_wdata;
          cmd_d.wstrb = cmd_wstrb;
          lat_d       = '0;
          if (cmd_we) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = ST_WR_AW_W;
          end else begin
            arvalid_d = 1'b1;
            state_d   = ST_RD_AR;
          end
        end
      end
      ST_WR_AW_W: begin
        lat_d = lat_inc;
        if (M_AXI_AWREADY) awvalid_d = 1'b0;
        if (M_AXI_WREADY)  wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = ST_WR_B;
        end
      end
      ST_WR_B: begin
        lat_d = lat_inc;
        if (M_AXI_BVALID) begin
          bready_d    = 1'b0;
          resp_d      = M_AXI_BRESP;
          rdata_d     = '0;
          rsp_valid_d = 1'b1;
          state_d     = ST_RSP;
        end
      end
      ST_RD_AR: begin
        lat_d = lat_inc;
        if (M_AXI_ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = ST_RD_R;
        end
      end
      ST_RD_R: begin
        lat_d = lat_inc;
        if (M_AXI_RVALID) begin
          rready_d    = 1'b0;
          rdata_d     = AXIL_DATA_W'(M_AXI_RDATA);
          resp_d      = M_AXI_RRESP;
          rsp_valid_d = 1'b1;
          state_d     = ST_RSP;
        end
      end
      ST_RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Accept only from IDLE, and never while reset is held.
  assign cmd_ready = (state_q == ST_IDLE) && !ARESET;

  // AXI and response outputs come straight from registers.
  assign M_AXI_AWADDR  = ADDR_WIDTH'(cmd_q.addr);
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = DATA_WIDTH'(cmd_q.wdata);
  assign M_AXI_WSTRB   = STRB_W'(cmd_q.wstrb);
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARADDR  = ADDR_WIDTH'(cmd_q.addr);
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_q;

  assign rsp_valid   = rsp_valid_q;
  assign rsp_we      = cmd_q.we;
  assign rsp_rdata   = rdata_q;
  assign rsp_resp    = resp_q;
  assign rsp_latency = lat_q;

  // Slave responses are only legal while this master is waiting for them.
  always_ff @(posedge ACLK) begin
    if (!ARESET) begin
      assert (!(M_AXI_BVALID && state_q != ST_WR_B))
        else $error("axil_cmd_master: BVALID seen outside WR_B");
      assert (!(M_AXI_RVALID && state_q != ST_RD_R))
        else $error("axil_cmd_master: RVALID seen outside RD_R");
    end
  end

endmodule

// File: tb/tb_axil_cmd_master.sv
// Directed bench: axil_cmd_master driving a configurable 4-register AXI4-Lite slave model.
module tb_axil_cmd_master;
  import axil_pkg::*;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_we = 1'b0;
  logic [3:0]  cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic        rsp_we;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [15:0] rsp_latency;
  logic [3:0]  M_AXI_AWADDR;
  logic [2:0]  M_AXI_AWPROT;
  logic        M_AXI_AWVALID, M_AXI_AWREADY;
  logic [31:0] M_AXI_WDATA;
  logic [3:0]  M_AXI_WSTRB;
  logic        M_AXI_WVALID, M_AXI_WREADY;
  logic [1:0]  M_AXI_BRESP;
  logic        M_AXI_BVALID, M_AXI_BREADY;
  logic [3:0]  M_AXI_ARADDR;
  logic [2:0]  M_AXI_ARPROT;
  logic        M_AXI_ARVALID, M_AXI_ARREADY;
  logic [31:0] M_AXI_RDATA;
  logic [1:0]  M_AXI_RRESP;
  logic        M_AXI_RVALID, M_AXI_RREADY;

  int n_vec = 0;
  int n_mis = 0;

  always #5 ACLK = ~ACLK;

  axil_cmd_master #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .LAT_WIDTH(16)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_we(rsp_we), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_latency(rsp_latency),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT), .M_AXI_AWVALID(M_AXI_AWVALID),
    .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WVALID(M_AXI_WVALID),
    .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT), .M_AXI_ARVALID(M_AXI_ARVALID),
    .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RVALID(M_AXI_RVALID),
    .M_AXI_RREADY(M_AXI_RREADY)
  );

  // ---------------- slave model: 4 x 32-bit registers, programmable waits/responses
  int         aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
  logic [1:0] bresp_cfg = RESP_OKAY, rresp_cfg = RESP_OKAY;
  int         b_count = 0;
  logic [31:0] slv_reg [4];
  logic        aw_got, w_got, ar_got;
  int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  logic [3:0]  slv_awaddr, slv_araddr;
  logic [31:0] slv_wdata;
  logic [3:0]  slv_wstrb;

  assign M_AXI_AWREADY = M_AXI_AWVALID && !aw_got && (aw_cnt >= aw_delay);
  assign M_AXI_WREADY  = M_AXI_WVALID && !w_got && (w_cnt >= w_delay);
  assign M_AXI_BVALID  = aw_got && w_got && (b_cnt >= b_delay);
  assign M_AXI_BRESP   = bresp_cfg;
  assign M_AXI_ARREADY = M_AXI_ARVALID && !ar_got && (ar_cnt >= ar_delay);
  assign M_AXI_RVALID  = ar_got && (r_cnt >= r_delay);
  assign M_AXI_RDATA   = slv_reg[slv_araddr[3:2]];
  assign M_AXI_RRESP   = rresp_cfg;

  // Slave channel state: counts wait cycles, latches payloads, commits on B handshake.
  always @(posedge ACLK) begin
    if (ARESET) begin
      aw_got <= 1'b0; w_got <= 1'b0; ar_got <= 1'b0;
      aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
      slv_awaddr <= '0; slv_araddr <= '0; slv_wdata <= '0; slv_wstrb <= '0;
      for (int i = 0; i < 4; i++) slv_reg[i] <= '0;
    end else begin
      if (M_AXI_AWVALID && !aw_got) begin
        if (M_AXI_AWREADY) begin aw_got <= 1'b1; aw_cnt <= 0; slv_awaddr <= M_AXI_AWADDR; end
        else aw_cnt <= aw_cnt + 1;
      end
      if (M_AXI_WVALID && !w_got) begin
        if (M_AXI_WREADY) begin w_got <= 1'b1; w_cnt <= 0; slv_wdata <= M_AXI_WDATA; slv_wstrb <= M_AXI_WSTRB; end
        else w_cnt <= w_cnt + 1;
      end
      if (aw_got && w_got) begin
        if (M_AXI_BVALID && M_AXI_BREADY) begin
          for (int i = 0; i < 4; i++)
            if (slv_wstrb[i]) slv_reg[slv_awaddr[3:2]][8*i +: 8] <= slv_wdata[8*i +: 8];
          aw_got <= 1'b0; w_got <= 1'b0; b_cnt <= 0; b_count <= b_count + 1;
        end else if (!M_AXI_BVALID) b_cnt <= b_cnt + 1;
      end
      if (M_AXI_ARVALID && !ar_got) begin
        if (M_AXI_ARREADY) begin ar_got <= 1'b1; ar_cnt <= 0; slv_araddr <= M_AXI_ARADDR; end
        else ar_cnt <= ar_cnt + 1;
      end
      if (ar_got) begin
        if (M_AXI_RVALID && M_AXI_RREADY) begin ar_got <= 1'b0; r_cnt <= 0; end
        else if (!M_AXI_RVALID) r_cnt <= r_cnt + 1;
      end
    end
  end

  // ---------------- link checker: VALID held and payload stable until handshake, PROT zero
  int          viol = 0;
  logic        aw_hold, w_hold, ar_hold;
  logic [3:0]  aw_prev, ar_prev;
  logic [31:0] wd_prev;
  logic [3:0]  ws_prev;
  always @(posedge ACLK) begin
    int v;
    v = 0;
    if (ARESET) begin
      aw_hold <= 1'b0; w_hold <= 1'b0; ar_hold <= 1'b0;
    end else begin
      if (aw_hold && (!M_AXI_AWVALID || M_AXI_AWADDR != aw_prev)) v++;
      if (w_hold && (!M_AXI_WVALID || M_AXI_WDATA != wd_prev || M_AXI_WSTRB != ws_prev)) v++;
      if (ar_hold && (!M_AXI_ARVALID || M_AXI_ARADDR != ar_prev)) v++;
      if (M_AXI_AWVALID && (M_AXI_AWPROT != 3'b000 || M_AXI_AWADDR[1:0] != 2'b00)) v++;
      if (M_AXI_ARVALID && (M_AXI_ARPROT != 3'b000 || M_AXI_ARADDR[1:0] != 2'b00)) v++;
      aw_hold <= M_AXI_AWVALID && !M_AXI_AWREADY; aw_prev <= M_AXI_AWADDR;
      w_hold  <= M_AXI_WVALID && !M_AXI_WREADY;   wd_prev <= M_AXI_WDATA; ws_prev <= M_AXI_WSTRB;
      ar_hold <= M_AXI_ARVALID && !M_AXI_ARREADY; ar_prev <= M_AXI_ARADDR;
      viol <= viol + v;
    end
  end

  // ---------------- helpers
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present a command at a negedge and return at the negedge after it is accepted.
  task automatic send(input logic we, input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    int n;
    n = 0;
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    while (!cmd_ready && n < 100) begin @(negedge ACLK); n++; end
    chk("cmd_accept", 64'(cmd_ready), 64'(1));
    @(posedge ACLK);
    @(negedge ACLK);
    cmd_valid = 1'b0;
  endtask

  // Wait (bounded) for a response, capture it, then complete the handshake.
  task automatic get_rsp(output logic we, output logic [31:0] d, output logic [1:0] r, output logic [15:0] lat);
    int n;
    n = 0;
    while (!rsp_valid && n < 200) begin @(negedge ACLK); n++; end
    chk("rsp_arrive", 64'(rsp_valid), 64'(1));
    we = rsp_we; d = rsp_rdata; r = rsp_resp; lat = rsp_latency;
    rsp_ready = 1'b1;
    @(posedge ACLK);
    @(negedge ACLK);
    rsp_ready = 1'b0;
  endtask

  task automatic xact(input string tag, input logic we, input logic [3:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic [31:0] exp_rd, input logic [1:0] exp_resp,
                      input logic [15:0] exp_lat);
    logic r_we; logic [31:0] r_d; logic [1:0] r_r; logic [15:0] r_l;
    send(we, a, d, s);
    get_rsp(r_we, r_d, r_r, r_l);
    chk({tag, ".we"},    64'(r_we), 64'(we));
    chk({tag, ".rdata"}, 64'(r_d),  64'(exp_rd));
    chk({tag, ".resp"},  64'(r_r),  64'(exp_resp));
    chk({tag, ".lat"},   64'(r_l),  64'(exp_lat));
  endtask

  // Safety net against a stuck run.
  initial begin
    #200000;
    $display("FAIL watchdog: run did not reach the summary");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence
  initial begin
    logic r_we; logic [31:0] r_d; logic [1:0] r_r; logic [15:0] r_l;
    int n;
    int b0;
    logic ok;

    // Reset: everything quiet, no accept while ARESET is high.
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    chk("rst.cmd_ready", 64'(cmd_ready), 64'(0));
    chk("rst.valids", 64'({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID, M_AXI_BREADY, M_AXI_RREADY, rsp_valid}), 64'(0));
    chk("rst.rsp_fields", 64'({rsp_rdata, rsp_resp, rsp_latency}), 64'(0));
    ARESET = 1'b0;
    #1 chk("rst.idle_ready", 64'(cmd_ready), 64'(1));

    // Unaligned write with partial strobes, then readback of the aligned word.
    xact("t3.wr", 1'b1, 4'h7, 32'hDEADBEEF, 4'h3, 32'h0, RESP_OKAY, 16'd2);
    chk("t3.awaddr", 64'(slv_awaddr), 64'(4'h4));
    xact("t3.rd", 1'b0, 4'h4, 32'h0, 4'h0, 32'h0000BEEF, RESP_OKAY, 16'd2);

    // Full-word writes to all four registers, then read them back.
    for (int i = 0; i < 4; i++)
      xact("t1.wr", 1'b1, 4'(4 * i), 32'(i + 1), 4'hF, 32'h0, RESP_OKAY, 16'd2);
    for (int i = 0; i < 4; i++)
      xact("t1.rd", 1'b0, 4'(4 * i), 32'h0, 4'h0, 32'(i + 1), RESP_OKAY, 16'd2);

    // W accepted three cycles before AW: each VALID drops right after its own handshake.
    b0 = b_count;
    aw_delay = 3; w_delay = 0;
    send(1'b1, 4'h8, 32'h11112222, 4'hF);
    chk("t2.both_valid", 64'({M_AXI_AWVALID, M_AXI_WVALID}), 64'(2'b11));
    @(negedge ACLK);
    chk("t2.w_dropped", 64'({M_AXI_AWVALID, M_AXI_WVALID}), 64'(2'b10));
    @(negedge ACLK);
    @(negedge ACLK);
    chk("t2.aw_still", 64'({M_AXI_AWVALID, M_AXI_BREADY}), 64'(2'b10));
    @(negedge ACLK);
    chk("t2.aw_dropped", 64'({M_AXI_AWVALID, M_AXI_BREADY}), 64'(2'b01));
    get_rsp(r_we, r_d, r_r, r_l);
    chk("t2.lat_staggered", 64'(r_l), 64'(5));
    aw_delay = 0;
    send(1'b1, 4'hC, 32'h33334444, 4'hF);
    @(negedge ACLK);
    chk("t2.same_cycle", 64'({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY}), 64'(3'b001));
    get_rsp(r_we, r_d, r_r, r_l);
    chk("t2.lat_same", 64'(r_l), 64'(2));
    chk("t2.b_count", 64'(b_count - b0), 64'(2));

    // Error responses pass through; five slave wait cycles stretch latency to 7.
    bresp_cfg = RESP_SLVERR; rresp_cfg = RESP_DECERR; b_delay = 5; r_delay = 5;
    xact("t4.wr", 1'b1, 4'h0, 32'h00000055, 4'hF, 32'h0, RESP_SLVERR, 16'd7);
    xact("t4.rd", 1'b0, 4'h0, 32'h0, 4'h0, 32'h00000055, RESP_DECERR, 16'd7);
    bresp_cfg = RESP_OKAY; rresp_cfg = RESP_OKAY; b_delay = 0; r_delay = 0;

    // Response back-pressure with a command waiting.
    send(1'b1, 4'h8, 32'h0000A5A5, 4'hF);
    n = 0;
    while (!rsp_valid && n < 50) begin @(negedge ACLK); n++; end
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 4'hC; cmd_wdata = 32'h00000077; cmd_wstrb = 4'hF;
    for (int i = 0; i < 10; i++) begin
      @(negedge ACLK);
      ok = rsp_valid && rsp_we && (rsp_rdata == 32'h0) && (rsp_resp == RESP_OKAY) &&
           (rsp_latency == 16'd2) && !cmd_ready && !M_AXI_AWVALID && !M_AXI_WVALID &&
           !M_AXI_ARVALID && !M_AXI_BREADY && !M_AXI_RREADY;
      chk("t5.hold", 64'(ok), 64'(1));
    end
    rsp_ready = 1'b1;
    @(posedge ACLK);
    @(negedge ACLK);
    rsp_ready = 1'b0;
    chk("t5.after_rsp", 64'({cmd_ready, rsp_valid, M_AXI_AWVALID}), 64'(3'b100));
    @(posedge ACLK);
    @(negedge ACLK);
    cmd_valid = 1'b0;
    chk("t5.next_accept", 64'(M_AXI_AWVALID), 64'(1));
    get_rsp(r_we, r_d, r_r, r_l);
    chk("t5.next_lat", 64'(r_l), 64'(2));

    // Reset while waiting for B abandons the transaction.
    b_delay = 20;
    send(1'b1, 4'h0, 32'hCAFEF00D, 4'hF);
    n = 0;
    while (!M_AXI_BREADY && n < 50) begin @(negedge ACLK); n++; end
    chk("t6.in_wr_b", 64'(M_AXI_BREADY), 64'(1));
    ARESET = 1'b1;
    #1 chk("t6.rst_cmd_ready", 64'(cmd_ready), 64'(0));
    @(posedge ACLK);
    @(negedge ACLK);
    ARESET = 1'b0;
    #1;
    chk("t6.quiet", 64'({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID, M_AXI_BREADY, M_AXI_RREADY, rsp_valid}), 64'(0));
    chk("t6.idle", 64'(cmd_ready), 64'(1));
    chk("t6.lat_clr", 64'(rsp_latency), 64'(0));
    b_delay = 0;
    @(negedge ACLK);
    xact("t6.wr", 1'b1, 4'hC, 32'h00001234, 4'hF, 32'h0, RESP_OKAY, 16'd2);
    xact("t6.rd", 1'b0, 4'hC, 32'h0, 4'h0, 32'h00001234, RESP_OKAY, 16'd2);

    repeat (2) @(negedge ACLK);
    chk("link_protocol", 64'(viol), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
